nonce_result_scanner: RTL and testbench

//  Downstream stage of the bitcoin hash engine. After the engine finishes, scans the H0 word of each nonce's

---
 rtl/nonce_result_scanner.sv | 161 ++++++++++++++++
 tb/tb_nonce_result_scanner.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_result_scanner.sv
// Scans the H0 word of every nonce against a difficulty target, keeps the lowest H0 and its nonce,
// then writes a 3-word report {found/best, min H0, hit count} and pulses done.
module nonce_result_scanner #(
  parameter int NUM_NONCES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] result_addr,
  input  logic [15:0] report_addr,
  input  logic [31:0] target,
  output logic        done,
  output logic        found,
  output logic [31:0] best_nonce,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int IW = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1;
  localparam int CW = $clog2(NUM_NONCES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_CAP,
    S_WR0,
    S_WR1,
    S_WR2,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [15:0]     r_result_addr;
  logic [15:0]     r_report_addr;
  logic [31:0]     r_target;
  logic [IW-1:0]   r_idx;
  logic [31:0]     r_min;
  logic [IW-1:0]   r_best;
  logic [CW-1:0]   r_hits;
  logic            r_found_out;
  logic [31:0]     r_best_out;
  logic            w_last;
  logic            w_hit;
  logic            w_lower;
  logic            w_found;

  assign mem_clk    = clk;
  assign found      = r_found_out;
  assign best_nonce = r_best_out;

  assign w_last  = (r_idx == IW'(NUM_NONCES - 1));
  assign w_hit   = (mem_read_data < r_target);
  assign w_lower = (mem_read_data < r_min);
  assign w_found = (r_hits != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    done           = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = 16'h0000;
    mem_write_data = 32'h0000_0000;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_RD_REQ;
      end
      S_RD_REQ: begin
        mem_addr = r_result_addr + 16'(r_idx);
        w_next   = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        mem_addr = r_result_addr + 16'(r_idx);
        w_next   = S_RD_CAP;
      end
      S_RD_CAP: begin
        mem_addr = r_result_addr + 16'(r_idx);
        w_next   = w_last ? S_WR0 : S_RD_REQ;
      end
      S_WR0: begin
        mem_we         = 1'b1;
        mem_addr       = r_report_addr;
        mem_write_data = {w_found, 15'b0, 16'(r_best)};
        w_next         = S_WR1;
      end
      S_WR1: begin
        mem_we         = 1'b1;
        mem_addr       = r_report_addr + 16'd1;
        mem_write_data = r_min;
        w_next         = S_WR2;
      end
      S_WR2: begin
        mem_we         = 1'b1;
        mem_addr       = r_report_addr + 16'd2;
        mem_write_data = 32'(r_hits);
        w_next         = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result_addr <= '0;
      r_report_addr <= '0;
      r_target      <= '0;
      r_idx         <= '0;
      r_min         <= '0;
      r_best        <= '0;
      r_hits        <= '0;
      r_found_out   <= 1'b0;
      r_best_out    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_result_addr <= result_addr;
            r_report_addr <= report_addr;
            r_target      <= target;
            r_idx         <= '0;
            r_min         <= 32'hFFFF_FFFF;
            r_best        <= '0;
            r_hits        <= '0;
            r_found_out   <= 1'b0;
            r_best_out    <= '0;
          end
        end
        S_RD_CAP: begin
          if (w_hit) r_hits <= r_hits + CW'(1);
          // Strict less-than keeps the earliest nonce on ties
          if (w_lower) begin
            r_min  <= mem_read_data;
            r_best <= r_idx;
          end
          if (!w_last) r_idx <= r_idx + IW'(1);
        end
        S_WR2: begin
          r_found_out <= w_found;
          r_best_out  <= 32'(r_best);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_result_scanner.sv
// Bench for nonce_result_scanner: word memory model, directed spec scenarios and randomized scans.
module tb_nonce_result_scanner;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] result_addr, report_addr;
  logic [31:0] target;
  logic        done, found, mem_clk, mem_we;
  logic [31:0] best_nonce, mem_write_data, mem_read_data;
  logic [15:0] mem_addr;

  logic [31:0] mem [0:65535];
  logic [31:0] rd_q;
  logic        tb_we;
  logic [15:0] tb_waddr;
  logic [31:0] tb_wdata;

  int checks = 0, errors = 0;

  logic [31:0] h [0:N-1];
  logic [31:0] exp_min;
  int          exp_hits, exp_best;
  logic        exp_found;

  int          w_n, w_first, w_last, d_cnt, d_cyc;
  logic [15:0] w_addr [0:2];
  logic [31:0] w_data [0:2];
  logic        d_found;
  logic [31:0] d_best;

  nonce_result_scanner #(.NUM_NONCES(N)) dut (
    .clk(clk), .reset(reset), .start(start), .result_addr(result_addr),
    .report_addr(report_addr), .target(target), .done(done), .found(found),
    .best_nonce(best_nonce), .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_write_data;
    else if (tb_we) mem[tb_waddr] <= tb_wdata;
    rd_q <= mem[mem_addr];
  end
  assign mem_read_data = rd_q;

  task automatic poke(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk); tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    @(negedge clk); tb_we = 1'b0;
  endtask

  task automatic load_h(input logic [15:0] base);
    for (int n = 0; n < N; n++) poke(base + 16'(n), h[n]);
  endtask

  // Reference: minimum is the smallest H0, best is the first nonce holding it
  task automatic model(input logic [31:0] tgt);
    exp_min = 32'hFFFF_FFFF; exp_hits = 0; exp_best = -1;
    for (int n = 0; n < N; n++) begin
      if (h[n] < exp_min) exp_min = h[n];
      if (h[n] < tgt) exp_hits++;
    end
    for (int n = N - 1; n >= 0; n--) if (h[n] == exp_min) exp_best = n;
    exp_found = (exp_hits > 0);
  endtask

  // Cycle k is observed at the negedge inside it; start is accepted in cycle 0
  task automatic run_scan(input logic [15:0] rb, input logic [15:0] wb, input logic [31:0] tgt,
                          input bit inject);
    @(negedge clk);
    result_addr = rb; report_addr = wb; target = tgt; start = 1'b1;
    w_n = 0; w_first = -1; w_last = -1; d_cnt = 0; d_cyc = -1; d_found = 1'b0; d_best = '0;
    for (int k = 1; k <= 3 * N + 12; k++) begin
      @(negedge clk);
      if (mem_we) begin
        if (w_n < 3) begin w_addr[w_n] = mem_addr; w_data[w_n] = mem_write_data; end
        if (w_first < 0) w_first = k;
        w_last = k;
        w_n++;
      end
      if (done) begin d_cnt++; d_cyc = k; d_found = found; d_best = best_nonce; end
      if (inject && (k == 10 || k == 30 || k == 3 * N + 4)) begin
        start = 1'b1; result_addr = ~rb; report_addr = ~wb; target = 32'h0;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (found !== 1'b0) begin errors++; $display("FAIL reset_found got %b exp 0", found); end
    checks++; if (best_nonce !== 32'h0) begin errors++; $display("FAIL reset_best got %h exp 0", best_nonce); end
    checks++; if ({mem_we, mem_addr, mem_write_data} !== 49'h0) begin
      errors++; $display("FAIL reset_mem got we=%b a=%h d=%h exp all 0", mem_we, mem_addr, mem_write_data);
    end
    @(posedge clk); #1;
    checks++; if (mem_clk !== clk) begin errors++; $display("FAIL mem_clk got %b exp %b", mem_clk, clk); end
  endtask

  task automatic test_descending;
    for (int n = 0; n < N; n++) h[n] = 32'h1000_0000 - 32'(n);
    load_h(16'h0100);
    run_scan(16'h0100, 16'h0200, 32'h0FFF_FFF8, 1'b0);
    checks++; if (w_data[0] !== 32'h8000_000F) begin errors++; $display("FAIL t1_word0 got %h exp 8000000f", w_data[0]); end
    checks++; if (w_data[1] !== 32'h0FFF_FFF1) begin errors++; $display("FAIL t1_min got %h exp 0ffffff1", w_data[1]); end
    checks++; if (w_data[2] !== 32'd7) begin errors++; $display("FAIL t1_hits got %h exp 7", w_data[2]); end
    checks++; if (d_found !== 1'b1 || d_best !== 32'd15) begin
      errors++; $display("FAIL t1_outputs got found=%b best=%0d exp found=1 best=15", d_found, d_best);
    end
    checks++; if (mem[16'h0201] !== 32'h0FFF_FFF1) begin errors++; $display("FAIL t1_memword got %h exp 0ffffff1", mem[16'h0201]); end
  endtask

  task automatic test_no_hits;
    for (int n = 0; n < N; n++) h[n] = 32'h8000_0000;
    load_h(16'h1000);
    run_scan(16'h1000, 16'h1100, 32'h0000_0001, 1'b0);
    checks++; if (w_data[0] !== 32'h0) begin errors++; $display("FAIL t2_word0 got %h exp 0", w_data[0]); end
    checks++; if (w_data[1] !== 32'h8000_0000) begin errors++; $display("FAIL t2_min got %h exp 80000000", w_data[1]); end
    checks++; if (w_data[2] !== 32'h0) begin errors++; $display("FAIL t2_hits got %h exp 0", w_data[2]); end
    checks++; if (d_found !== 1'b0 || d_best !== 32'd0) begin
      errors++; $display("FAIL t2_outputs got found=%b best=%0d exp found=0 best=0", d_found, d_best);
    end
  endtask

  task automatic test_tie;
    for (int n = 0; n < N; n++) h[n] = 32'h0001_0000 + 32'(n);
    h[3] = 32'h0000_00FF; h[11] = 32'h0000_00FF;
    load_h(16'h2000);
    run_scan(16'h2000, 16'h2100, 32'h0000_1000, 1'b0);
    checks++; if (w_data[0] !== 32'h8000_0003) begin errors++; $display("FAIL t3_word0 got %h exp 80000003", w_data[0]); end
    checks++; if (w_data[1] !== 32'h0000_00FF) begin errors++; $display("FAIL t3_min got %h exp 000000ff", w_data[1]); end
    checks++; if (w_data[2] !== 32'd2) begin errors++; $display("FAIL t3_hits got %h exp 2", w_data[2]); end
    checks++; if (d_best !== 32'd3) begin errors++; $display("FAIL t3_best got %0d exp 3", d_best); end
  endtask

  task automatic test_timing;
    for (int n = 0; n < N; n++) h[n] = 32'h1000_0000 - 32'(n);
    load_h(16'h0100);
    run_scan(16'h0100, 16'h0300, 32'h0FFF_FFF8, 1'b1);
    checks++; if (w_first !== 49 || w_last !== 51 || w_n !== 3) begin
      errors++; $display("FAIL t4_we_window got first=%0d last=%0d n=%0d exp 49 51 3", w_first, w_last, w_n);
    end
    checks++; if (d_cyc !== 52 || d_cnt !== 1) begin
      errors++; $display("FAIL t4_done got cycle=%0d count=%0d exp 52 1", d_cyc, d_cnt);
    end
    checks++; if (w_addr[0] !== 16'h0300 || w_addr[2] !== 16'h0302) begin
      errors++; $display("FAIL t4_addr got %h %h exp 0300 0302", w_addr[0], w_addr[2]);
    end
    checks++; if (w_data[0] !== 32'h8000_000F || w_data[2] !== 32'd7) begin
      errors++; $display("FAIL t4_ignored_start got %h %h exp 8000000f 7", w_data[0], w_data[2]);
    end
  endtask

  task automatic test_reset_mid;
    int we_seen;
    for (int i = 0; i < 3; i++) poke(16'h0400 + 16'(i), 32'hDEAD_0000 + 32'(i));
    for (int n = 0; n < N; n++) h[n] = 32'h1000_0000 - 32'(n);
    load_h(16'h0500);
    @(negedge clk);
    result_addr = 16'h0500; report_addr = 16'h0400; target = 32'h0FFF_FFF8; start = 1'b1;
    for (int k = 1; k <= 24; k++) begin @(negedge clk); start = 1'b0; end
    reset = 1'b1; #1;
    checks++; if ({done, found, best_nonce, mem_we, mem_addr, mem_write_data} !== 83'h0) begin
      errors++; $display("FAIL t5_abort got done=%b found=%b best=%h we=%b a=%h d=%h exp all 0",
                         done, found, best_nonce, mem_we, mem_addr, mem_write_data);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0; we_seen = 0;
    repeat (60) begin @(negedge clk); if (mem_we) we_seen++; end
    checks++; if (we_seen !== 0) begin errors++; $display("FAIL t5_no_write got %0d write cycles exp 0", we_seen); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem[16'h0400 + 16'(i)] !== 32'hDEAD_0000 + 32'(i)) begin
        errors++; $display("FAIL t5_report_untouched[%0d] got %h exp %h", i, mem[16'h0400 + 16'(i)], 32'hDEAD_0000 + 32'(i));
      end
    end
    run_scan(16'h0500, 16'h0400, 32'h0FFF_FFF8, 1'b0);
    checks++; if (d_cnt !== 1 || w_data[0] !== 32'h8000_000F || w_data[1] !== 32'h0FFF_FFF1 || w_data[2] !== 32'd7) begin
      errors++; $display("FAIL t5_fresh got done=%0d %h %h %h exp 1 8000000f 0ffffff1 7", d_cnt, w_data[0], w_data[1], w_data[2]);
    end
  endtask

  task automatic test_wrap;
    for (int n = 0; n < N; n++) h[n] = 32'h0000_5000 + 32'(n * 3);
    load_h(16'h0010);
    model(32'h0000_5010);
    run_scan(16'h0010, 16'hFFFF, 32'h0000_5010, 1'b0);
    checks++; if (w_addr[0] !== 16'hFFFF || w_addr[1] !== 16'h0000 || w_addr[2] !== 16'h0001) begin
      errors++; $display("FAIL t6_addr got %h %h %h exp ffff 0000 0001", w_addr[0], w_addr[1], w_addr[2]);
    end
    checks++; if (mem[16'hFFFF] !== {exp_found, 15'b0, 16'(exp_best)} || mem[16'h0000] !== exp_min
                  || mem[16'h0001] !== 32'(exp_hits)) begin
      errors++; $display("FAIL t6_mem got %h %h %h exp %h %h %h", mem[16'hFFFF], mem[16'h0000], mem[16'h0001],
                         {exp_found, 15'b0, 16'(exp_best)}, exp_min, 32'(exp_hits));
    end
    for (int n = 0; n < N; n++) begin
      checks++; if (mem[16'h0010 + 16'(n)] !== h[n]) begin
        errors++; $display("FAIL t6_result_area[%0d] got %h exp %h", n, mem[16'h0010 + 16'(n)], h[n]);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] tgt;
    logic [15:0] rb, wb;
    for (int it = 0; it < 8; it++) begin
      for (int n = 0; n < N; n++)
        h[n] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF
             : ((32'($urandom_range(0, 7)) << 28) | 32'($urandom_range(0, 3)));
      if (it == 2) for (int n = 0; n < N; n++) h[n] = 32'hFFFF_FFFF;
      tgt = (it == 0) ? 32'h0 : (it == 1) ? 32'hFFFF_FFFF : (32'($urandom_range(0, 8)) << 28);
      rb = 16'($urandom_range(16'h3000, 16'h7FF0));
      wb = rb + 16'(N) + 16'($urandom_range(0, 100));
      load_h(rb);
      model(tgt);
      run_scan(rb, wb, tgt, 1'b0);
      checks++; if (w_data[0] !== {exp_found, 15'b0, 16'(exp_best)}) begin
        errors++; $display("FAIL rnd%0d_word0 got %h exp %h", it, w_data[0], {exp_found, 15'b0, 16'(exp_best)});
      end
      checks++; if (w_data[1] !== exp_min) begin errors++; $display("FAIL rnd%0d_min got %h exp %h", it, w_data[1], exp_min); end
      checks++; if (w_data[2] !== 32'(exp_hits)) begin errors++; $display("FAIL rnd%0d_hits got %h exp %h", it, w_data[2], 32'(exp_hits)); end
      checks++; if (d_found !== exp_found || d_best !== 32'(exp_best) || d_cnt !== 1) begin
        errors++; $display("FAIL rnd%0d_outputs got found=%b best=%0d done=%0d exp %b %0d 1", it, d_found, d_best, d_cnt, exp_found, exp_best);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; result_addr = '0; report_addr = '0; target = '0;
    tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
    repeat (3) @(negedge clk);
    test_reset;
    @(negedge clk); reset = 1'b0;
    test_descending;
    test_no_hits;
    test_tie;
    test_timing;
    test_reset_mid;
    test_wrap;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
